// File: rtl/mul_pkg.sv
// Shared definitions for the RV64M multiply path: operand width, op encodings
// and the per-op decode helpers used by the issue stage and the decoder.
package mul_pkg;

    localparam int XLEN  = 64;
    localparam int PRODW = 2 * XLEN;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    // Only MULH needs a signed x signed array; MULHSU is fixed up after an unsigned multiply.
    function automatic logic op_is_signed(input mul_op_t op);
        case (op)
            OP_MULH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_needs_hsu_fix(input mul_op_t op);
        case (op)
            OP_MULHSU: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mul.sv
// Combinational W x W -> 2W multiply array; sign selects signed x signed,
// otherwise unsigned x unsigned.
module mul
    import mul_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sign,
    output logic [2*W-1:0] res
);

    logic [2*W-1:0] a_ext_s;
    logic [2*W-1:0] b_ext_s;

    // Extending to 2W and keeping the low 2W product bits gives both the signed and unsigned result.
    assign a_ext_s = {{W{sign & a[W-1]}}, a};
    assign b_ext_s = {{W{sign & b[W-1]}}, b};
    assign res     = a_ext_s * b_ext_s;

endmodule

// File: rtl/mul_pipe.sv
// Two-stage RV64M multiply issue stage: S1 registers the request, the multiply,
// MULHSU fix-up and word select run S1->S2, S2 holds the result for writeback.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [TAGW-1:0] out_tag
);

    logic            s1_v_q,   s1_v_d;
    mul_op_t         s1_op_q,  s1_op_d;
    logic [XLEN-1:0] s1_a_q,   s1_a_d;
    logic [XLEN-1:0] s1_b_q,   s1_b_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;

    logic            s2_v_q,   s2_v_d;
    logic [XLEN-1:0] s2_res_q, s2_res_d;
    logic [TAGW-1:0] s2_tag_q, s2_tag_d;

    logic            s2_adv_s;
    logic            s1_adv_s;
    logic            accept_s;
    logic            out_hs_s;
    logic            sign_s;
    logic [PRODW-1:0] prod_s;
    logic [XLEN-1:0] hsu_sub_s;
    logic [XLEN-1:0] hi_s;
    logic [XLEN-1:0] res_sel_s;

    assign s2_adv_s = !s2_v_q || out_ready;
    assign s1_adv_s = s1_v_q && s2_adv_s;
    assign in_ready = (!s1_v_q || s2_adv_s) && !flush;
    assign accept_s = in_valid && in_ready;
    assign out_hs_s = s2_v_q && out_ready;

    assign sign_s = op_is_signed(s1_op_q);

    mul #(
        .W (XLEN)
    ) u_mul (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .sign (sign_s),
        .res  (prod_s)
    );

    // MULHSU: the unsigned high word over-counts by b whenever rs1 is negative.
    always_comb begin
        hsu_sub_s = {XLEN{1'b0}};
        if (op_needs_hsu_fix(s1_op_q) && s1_a_q[XLEN-1]) begin
            hsu_sub_s = s1_b_q;
        end else begin
            hsu_sub_s = {XLEN{1'b0}};
        end
        hi_s = prod_s[PRODW-1:XLEN] - hsu_sub_s;
    end

    // Low or (corrected) high word select.
    always_comb begin
        res_sel_s = {XLEN{1'b0}};
        case (s1_op_q)
            OP_MUL:    res_sel_s = prod_s[XLEN-1:0];
            OP_MULH:   res_sel_s = hi_s;
            OP_MULHSU: res_sel_s = hi_s;
            OP_MULHU:  res_sel_s = hi_s;
            default:   res_sel_s = {XLEN{1'b0}};
        endcase
    end

    // S1 next state: flush kills, accept loads, an unreplaced advance empties.
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_tag_d = s1_tag_q;
        if (flush) begin
            s1_v_d = 1'b0;
        end else if (accept_s) begin
            s1_v_d   = 1'b1;
            s1_op_d  = mul_op_t'(in_op);
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_tag_d = in_tag;
        end else if (s1_adv_s) begin
            s1_v_d = 1'b0;
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    // S2 next state: data only moves on advance, so a stalled result stays put.
    always_comb begin
        s2_v_d   = s2_v_q;
        s2_res_d = s2_res_q;
        s2_tag_d = s2_tag_q;
        if (flush) begin
            s2_v_d = 1'b0;
        end else if (s1_adv_s) begin
            s2_v_d   = 1'b1;
            s2_res_d = res_sel_s;
            s2_tag_d = s1_tag_q;
        end else if (out_hs_s) begin
            s2_v_d = 1'b0;
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_op_q  <= OP_MUL;
            s1_a_q   <= {XLEN{1'b0}};
            s1_b_q   <= {XLEN{1'b0}};
            s1_tag_q <= {TAGW{1'b0}};
            s2_v_q   <= 1'b0;
            s2_res_q <= {XLEN{1'b0}};
            s2_tag_q <= {TAGW{1'b0}};
        end else begin
            s1_v_q   <= s1_v_d;
            s1_op_q  <= s1_op_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            s2_res_q <= s2_res_d;
            s2_tag_q <= s2_tag_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_res   = s2_res_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: expected results are queued on accept and
// matched against results captured at each output handshake.
module tb_mul_pipe;
    import mul_pkg::*;

    localparam int TAGW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [63:0]     in_a;
    logic [63:0]     in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_res;
    logic [TAGW-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0]     exp_res_q[$];
    logic [TAGW-1:0] exp_tag_q[$];
    logic [63:0]     obs_res_q[$];
    logic [TAGW-1:0] obs_tag_q[$];
    int              obs_cyc_q[$];

    always #5 clk = ~clk;

    mul_pipe #(.TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    // Reference: the mathematical 128-bit product for each op
    function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        case (op)
            2'b00: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            2'b01: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            2'b10: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            default: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
        endcase
    endfunction

    // One clock: sample handshakes mid-cycle, then move to just after the next rising edge
    task automatic tick(output logic acc);
        #3;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            obs_res_q.push_back(out_res);
            obs_tag_q.push_back(out_tag);
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAGW-1:0] tag, input logic [63:0] exp_res,
                         input bit keep, output int acc_cyc);
        logic acc;
        int   budget;
        acc = 1'b0;
        budget = 0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        while (!acc && budget < 50) begin
            acc_cyc = cyc;
            tick(acc);
            budget++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL issue_accept tag=%0d: accepted=0 after 50 cycles, required 1", tag);
        end else if (keep) begin
            exp_res_q.push_back(exp_res);
            exp_tag_q.push_back(tag);
        end
    endtask

    task automatic drain(input int n);
        logic acc;
        int   budget;
        budget = 0;
        while (obs_res_q.size() < n && budget < 200) begin
            tick(acc);
            budget++;
        end
        n_checks++;
        if (obs_res_q.size() < n) begin
            n_fail++;
            $display("FAIL drain_count: got %0d results, required %0d", obs_res_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_a = 64'd0;
        in_b = 64'd0;
        in_tag = '0;
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (out_res !== 64'd0) begin n_fail++; $display("FAIL reset_out_res: got %h, required 0", out_res); end
        n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag: got %0d, required 0", out_tag); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b, required 0", out_valid); end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_basic();
        int ac;
        out_ready = 1'b1;
        issue(2'b00, 64'd3, 64'd5, 5'd7, 64'h0000_0000_0000_000F, 1'b1, ac);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b one edge after accept, required 0", out_valid); end
        drain(1);
        while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
            logic [63:0] er, orr; logic [TAGW-1:0] et, ot; int oc;
            er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
            orr = obs_res_q.pop_front(); ot = obs_tag_q.pop_front(); oc = obs_cyc_q.pop_front();
            n_checks++; if (orr !== er) begin n_fail++; $display("FAIL basic_res: got %h, required %h", orr, er); end
            n_checks++; if (ot !== et) begin n_fail++; $display("FAIL basic_tag: got %0d, required %0d", ot, et); end
            n_checks++; if (oc - ac !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d edges, required 2", oc - ac); end
        end
    endtask

    task automatic test_all_ones_back_to_back();
        int ac0, ac1, ac2, prev;
        out_ready = 1'b1;
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,  64'h0000_0000_0000_0000, 1'b1, ac0);
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, ac1);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'h0000_0000_0000_0001, 1'b1, ac2);
        n_checks++; if (ac2 - ac0 !== 2) begin n_fail++; $display("FAIL b2b_accept_span: got %0d cycles, required 2", ac2 - ac0); end
        drain(3);
        prev = -1;
        while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
            logic [63:0] er, orr; logic [TAGW-1:0] et, ot; int oc;
            er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
            orr = obs_res_q.pop_front(); ot = obs_tag_q.pop_front(); oc = obs_cyc_q.pop_front();
            n_checks++; if (orr !== er) begin n_fail++; $display("FAIL ones_res tag=%0d: got %h, required %h", et, orr, er); end
            n_checks++; if (ot !== et) begin n_fail++; $display("FAIL ones_tag: got %0d, required %0d", ot, et); end
            if (prev >= 0) begin
                n_checks++; if (oc - prev !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles between results, required 1", oc - prev); end
            end
            prev = oc;
        end
    endtask

    task automatic test_mulhsu();
        int ac;
        out_ready = 1'b1;
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ac);
        issue(2'b10, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'h0000_0000_0000_0001, 1'b1, ac);
        issue(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd13, 64'hC000_0000_0000_0000, 1'b1, ac);
        drain(3);
        while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
            logic [63:0] er, orr; logic [TAGW-1:0] et, ot; int oc;
            er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
            orr = obs_res_q.pop_front(); ot = obs_tag_q.pop_front(); oc = obs_cyc_q.pop_front();
            n_checks++; if (orr !== er) begin n_fail++; $display("FAIL mulhsu_res tag=%0d: got %h, required %h", et, orr, er); end
            n_checks++; if (ot !== et) begin n_fail++; $display("FAIL mulhsu_tag: got %0d, required %0d (cyc %0d)", ot, et, oc); end
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [63:0] held_res;
        int prev;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_a = 64'd6; in_b = 64'd7; in_tag = 5'd1;
        tick(acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_accept_1: got %b, required 1", acc); end
        exp_res_q.push_back(64'd42); exp_tag_q.push_back(5'd1);
        in_op = 2'b11; in_a = 64'h8000_0000_0000_0000; in_b = 64'd4; in_tag = 5'd2;
        tick(acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_accept_2: got %b, required 1", acc); end
        exp_res_q.push_back(64'd2); exp_tag_q.push_back(5'd2);
        in_op = 2'b01; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd5; in_tag = 5'd3;
        held_res = out_res;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b, required 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc%0d: got %b, required 1", i, out_valid); end
            n_checks++; if (out_tag !== 5'd1) begin n_fail++; $display("FAIL bp_hold_tag cyc%0d: got %0d, required 1", i, out_tag); end
            n_checks++; if (out_res !== 64'd42 || out_res !== held_res) begin n_fail++; $display("FAIL bp_hold_res cyc%0d: got %h, required %h", i, out_res, 64'd42); end
            tick(acc);
            n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept cyc%0d: got %b, required 0", i, acc); end
        end
        out_ready = 1'b1;
        tick(acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_accept_3: got %b, required 1", acc); end
        exp_res_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); exp_tag_q.push_back(5'd3);
        in_valid = 1'b0;
        drain(3);
        prev = -1;
        while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
            logic [63:0] er, orr; logic [TAGW-1:0] et, ot; int oc;
            er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
            orr = obs_res_q.pop_front(); ot = obs_tag_q.pop_front(); oc = obs_cyc_q.pop_front();
            n_checks++; if (ot !== et) begin n_fail++; $display("FAIL bp_order: got tag %0d, required %0d", ot, et); end
            n_checks++; if (orr !== er) begin n_fail++; $display("FAIL bp_res tag=%0d: got %h, required %h", et, orr, er); end
            if (prev >= 0) begin
                n_checks++; if (oc - prev !== 1) begin n_fail++; $display("FAIL bp_gap: got %0d cycles between results, required 1", oc - prev); end
            end
            prev = oc;
        end
    endtask

    task automatic test_flush();
        logic acc;
        int ac;
        out_ready = 1'b1;
        issue(2'b00, 64'd9, 64'd9, 5'd4, 64'd81, 1'b0, ac);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 2'b00; in_a = 64'd10; in_b = 64'd10; in_tag = 5'd5;
        tick(acc);
        n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b, required 0", acc); end
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid cyc%0d: got %b, required 0", i, out_valid); end
            tick(acc);
        end
        n_checks++; if (obs_res_q.size() !== 0) begin n_fail++; $display("FAIL flush_leak: got %0d results, required 0", obs_res_q.size()); end
        obs_res_q.delete(); obs_tag_q.delete(); obs_cyc_q.delete();
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd6, 64'h0000_0000_0000_000F, 1'b1, ac);
        drain(1);
        while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
            logic [63:0] er, orr; logic [TAGW-1:0] et, ot; int oc;
            er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
            orr = obs_res_q.pop_front(); ot = obs_tag_q.pop_front(); oc = obs_cyc_q.pop_front();
            n_checks++; if (orr !== er) begin n_fail++; $display("FAIL post_flush_res: got %h, required %h", orr, er); end
            n_checks++; if (ot !== et) begin n_fail++; $display("FAIL post_flush_tag: got %0d, required %0d", ot, et); end
            n_checks++; if (oc - ac !== 2) begin n_fail++; $display("FAIL post_flush_latency: got %0d, required 2", oc - ac); end
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        int ac;
        out_ready = 1'b0;
        issue(2'b00, 64'd100, 64'd3, 5'd20, 64'd300, 1'b0, ac);
        issue(2'b00, 64'd7, 64'd7, 5'd21, 64'd49, 1'b0, ac);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight_valid: got %b, required 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid); end
        n_checks++; if (out_res !== 64'd0) begin n_fail++; $display("FAIL mid_rst_res: got %h, required 0", out_res); end
        n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL mid_rst_tag: got %0d, required 0", out_tag); end
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b, required 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc%0d: got out_valid %b, required 0", i, out_valid); end
            tick(acc);
        end
        n_checks++; if (obs_res_q.size() !== 0) begin n_fail++; $display("FAIL mid_stale_count: got %0d results, required 0", obs_res_q.size()); end
        obs_res_q.delete(); obs_tag_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_random();
        logic acc;
        int sent, budget;
        logic [63:0] a, b;
        logic [1:0] op;
        sent = 0;
        budget = 0;
        op = 2'($urandom_range(0, 3));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        while (sent < 24 && budget < 600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op = op; in_a = a; in_b = b; in_tag = 5'(sent);
            tick(acc);
            budget++;
            if (acc) begin
                exp_res_q.push_back(model(op, a, b));
                exp_tag_q.push_back(5'(sent));
                sent++;
                op = 2'($urandom_range(0, 3));
                a = ($urandom_range(0, 4) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
                b = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(sent);
        n_checks++; if (sent !== 24) begin n_fail++; $display("FAIL rand_sent: got %0d accepts, required 24", sent); end
        while (exp_res_q.size() > 0 && obs_res_q.size() > 0) begin
            logic [63:0] er, orr; logic [TAGW-1:0] et, ot; int oc;
            er = exp_res_q.pop_front(); et = exp_tag_q.pop_front();
            orr = obs_res_q.pop_front(); ot = obs_tag_q.pop_front(); oc = obs_cyc_q.pop_front();
            n_checks++; if (orr !== er) begin n_fail++; $display("FAIL rand_res tag=%0d: got %h, required %h (cyc %0d)", et, orr, er, oc); end
            n_checks++; if (ot !== et) begin n_fail++; $display("FAIL rand_tag: got %0d, required %0d", ot, et); end
        end
        n_checks++; if (obs_res_q.size() !== 0) begin n_fail++; $display("FAIL rand_extra: got %0d surplus results, required 0", obs_res_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones_back_to_back();
        test_mulhsu();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Pipelined 64-bit multiply issue stage for the ALU's RV64M multiply path. Accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and registers the operands. It drives the combinational `mul` array (64x64 → 128, `sign` selects signed/unsigned), applies the MULHSU correction, selects the low or high word, and presents a registered 64-bit result to writeback. Latency is 2 cycles, throughput is 1 op/cycle, and backpressure is supported.

## Interface
- `XLEN`, 64, operand/result width; only 64 is supported.
- `TAGW`, 5, width of the pass-through destination tag.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_op` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_a`, `in_b` in XLEN: operands (rs1, rs2).
- `in_tag` in TAGW: destination tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_res` out XLEN: selected result word.
- `out_tag` out TAGW: tag of `out_res`.

## Operation
- S1 register holds `{op, a, b, tag, s1_v}`. S2 register holds `{res, tag, s2_v}`. `out_valid = s2_v`.
- Between S1 and S2, `mul` is driven with S1 operands.
  - `sign=1` for MULH.
  - `sign=0` for MUL, MULHU and MULHSU.
- MULHSU correction: `hi = prod[127:64] - (a[63] ? b : 0)`, computed mod 2^64.
- Result select: MUL → `prod[63:0]` (sign-independent). MULH, MULHU, MULHSU → the corrected or raw `prod[127:64]`.
- Stall logic:
  - `s2_adv = !s2_v || out_ready`
  - `s1_adv = s1_v && s2_adv`
  - `in_ready = (!s1_v || s2_adv) && !flush`
- S1 loads on accept. S1 clears when it advances without a new accept. S2 loads when `s1_adv`. S2 clears on an output handshake without `s1_adv`.
- While `out_valid && !out_ready`, `out_res` and `out_tag` hold stable.
- Order is preserved. No op is dropped or duplicated.
- `flush`: next edge clears `s1_v` and `s2_v`. `in_ready` is 0 in the flush cycle, so there is no accept. Data registers may keep stale values.
- Reset (async, any cycle, including mid-operation): `s1_v=s2_v=0`, `out_res=0`, `out_tag=0`, all S1 data registers 0. Outputs after reset: `out_valid=0`, `in_ready=1`.

## Timing
- An accept at edge N gives `out_valid=1` after edge N+1, with the result visible in cycle N+1→N+2. Latency is 2 edges.
- With `out_ready` held high, back-to-back accepts give one result per cycle.
- With `out_ready` low: S2 fills, then S1 fills, and `in_ready` drops in the cycle S1 is full. Capacity is 2 ops.
- Consumer handshake and new accept in the same cycle: both happen and the pipeline advances. No bubble.
- The full multiply and correction path is one cycle (S1→S2). This is the block's critical path.

## Structure
- Shared package `mul_pkg`: `XLEN`, the op encodings `OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU`, and the `mul_op_t` typedef. The decoder uses the same package.
- Exactly one sub-module: the existing `mul` (ports `a`, `b`, `sign`, `res`), instantiated once.
- The MULHSU subtractor and the result mux are inline in `mul_pipe`.

## Test plan
- MUL a=3, b=5, tag=7, `out_ready=1`: `out_res=0x...000F`, `out_tag=7`, `out_valid` rises exactly 2 edges after accept.
- a=b=0xFFFF_FFFF_FFFF_FFFF:
  - MULH gives 0x0.
  - MULHU gives 0xFFFF_FFFF_FFFF_FFFE.
  - MUL gives 0x1.
  - Issue back-to-back: three results on three consecutive cycles.
- MULHSU:
  - a=0xFFFF_FFFF_FFFF_FFFF (−1), b=2 gives 0xFFFF_FFFF_FFFF_FFFF.
  - a=2, b=0xFFFF_FFFF_FFFF_FFFF gives 0x1.
  - a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 gives 0xC000_0000_0000_0000.
- Backpressure: `out_ready=0`, issue tags 1,2,3 continuously.
  - Tags 1 and 2 are accepted; `in_ready=0` with tag 3 pending.
  - `out_res`/`out_tag` stay stable.
  - Raise `out_ready`: results emerge 1, 2, 3 in order, no gaps after the first.
- Flush: accept tag 4, then assert `flush` one cycle later with `in_valid=1` (tag 5).
  - No result for tag 4 or tag 5.
  - `out_valid` stays 0.
  - Next accept (tag 6) behaves normally.
- Reset mid-operation: drop `rst_n` asynchronously between edges with 2 ops in flight.
  - `out_valid=0`, `out_res=0`, `out_tag=0` immediately.
  - `in_ready=1` after release.
  - No stale result appears afterwards.
